// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback.
// Latency: 3 cycles (beq/bne/j), 4 (R-type, I-type, sw), 5 (lw) with zero memory wait states.
// Backpressure: FETCH/MEM_READ/MEM_WRITE wait on mem_ready; after MEM_TIMEOUT idle cycles, pulse bus_error.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [2:0] alu_operation,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       bus_error
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB,
        MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP
    } state_t;

    state_t               state, state_next;
    logic [5:0]           op_q;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 wait_state;
    logic                 timeout;

    // Memory-facing states share one wait counter; completion in the timeout cycle wins.
    assign wait_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    assign timeout    = wait_state && !mem_ready && (wait_cnt == TIMEOUT_VAL);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Opcode is latched in DECODE so the IR-side opcode may change afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              op_q <= OP_RTYPE;
        else if (state == DECODE)  op_q <= opcode;
    end

    // Wait counter: cleared on any state change or timeout, counts idle memory cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   wait_cnt <= '0;
        else if (state_next != state)   wait_cnt <= '0;
        else if (timeout)               wait_cnt <= '0;
        else if (wait_state && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end

    // Next-state and output decode; all outputs derive from state so reset zeroes them at once.
    always_comb begin
        state_next    = state;
        alu_operation = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_done    = 1'b0;
        bus_error     = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                bus_error = timeout;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                // Branch target is precomputed here in case the instruction is a branch.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                  state_next = EXEC_R;
                    OP_LW, OP_SW:              state_next = MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_next = EXEC_I;
                    OP_BEQ, OP_BNE:            state_next = BRANCH;
                    OP_J:                      state_next = JUMP;
                    default: begin
                        bus_error  = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                bus_error = timeout;
                if (mem_ready)    state_next = MEM_WB;
                else if (timeout) state_next = FETCH;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                bus_error  = timeout;
                if (mem_ready || timeout) state_next = FETCH;
            end
            EXEC_R: begin
                alu_src_a     = 1'b1;
                alu_operation = 3'b010;
                state_next    = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ANDI: alu_operation = 3'b101;
                    OP_ORI:  alu_operation = 3'b111;
                    default: alu_operation = 3'b100;
                endcase
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_RTYPE);
                instr_done = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_operation = 3'b001;
                pc_source     = 2'b01;
                pc_write      = (op_q == OP_BNE) ? ~alu_zero : alu_zero;
                instr_done    = 1'b1;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected per-cycle control words queued and checked.
// Each step drives inputs on the falling edge and samples outputs 1 time unit later.
// Fixed-length stimulus; no open-ended waits.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] alu_operation;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       bus_error;
    } out_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] alu_operation;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, bus_error;

    out_t  obs;
    out_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(15), .TIMEOUT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .alu_operation(alu_operation), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .bus_error(bus_error)
    );

    assign obs = {alu_operation, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
                  i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                  instr_done, bus_error};

    function automatic out_t e_zero();
        out_t o = '0;
        return o;
    endfunction
    function automatic out_t e_fetch(input logic rdy, input logic be);
        out_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01;
        o.pc_write = rdy;  o.ir_write = rdy; o.bus_error = be;
        return o;
    endfunction
    function automatic out_t e_decode(input logic be);
        out_t o = '0;
        o.alu_src_b = 2'b11; o.bus_error = be;
        return o;
    endfunction
    function automatic out_t e_memaddr();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic out_t e_memrd();
        out_t o = '0;
        o.mem_read = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic out_t e_memwb();
        out_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_memwr(input logic rdy, input logic be);
        out_t o = '0;
        o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = rdy; o.bus_error = be;
        return o;
    endfunction
    function automatic out_t e_exec_r();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_operation = 3'b010;
        return o;
    endfunction
    function automatic out_t e_exec_i(input logic [2:0] aop);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_operation = aop;
        return o;
    endfunction
    function automatic out_t e_alu_wb(input logic rd);
        out_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = rd; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_branch(input logic pw);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_operation = 3'b001; o.pc_source = 2'b01;
        o.pc_write = pw; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_jump();
        out_t o = '0;
        o.pc_source = 2'b10; o.pc_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction

    // One clock step: drive inputs, queue the expected word, then pop and compare it.
    task automatic cyc(input string tag, input out_t e, input logic rst, input logic rdy,
                       input logic [5:0] op, input logic zero);
        out_t  ex;
        string t;
        @(negedge clk);
        reset_n   = rst;
        mem_ready = rdy;
        opcode    = op;
        alu_zero  = zero;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        n_tests++;
        assert (obs === ex) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", t, obs, ex);
        end
    endtask

    initial begin
        // Reset and R-type, zero wait states.
        cyc("rst_hold",  e_zero(),        1'b0, 1'b1, 6'b000000, 1'b0);
        cyc("idle",      e_zero(),        1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("r_fetch",   e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("r_decode",  e_decode(0),     1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("r_exec",    e_exec_r(),      1'b1, 1'b1, 6'b111111, 1'b0);
        cyc("r_wb",      e_alu_wb(1),     1'b1, 1'b1, 6'b001101, 1'b0);

        // lw with three wait states in MEM_READ; opcode scrambled after DECODE.
        cyc("lw_fetch",  e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("lw_decode", e_decode(0),     1'b1, 1'b1, 6'b100011, 1'b0);
        cyc("lw_addr",   e_memaddr(),     1'b1, 1'b1, 6'b101011, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("lw_wait", e_memrd(),     1'b1, 1'b0, 6'b000000, 1'b0);
        cyc("lw_rdy",    e_memrd(),       1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("lw_wb",     e_memwb(),       1'b1, 1'b1, 6'b000000, 1'b0);

        // beq taken, then bne with alu_zero=1 (not taken).
        cyc("beq_fetch", e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("beq_dec",   e_decode(0),     1'b1, 1'b1, 6'b000100, 1'b0);
        cyc("beq_br",    e_branch(1),     1'b1, 1'b1, 6'b000101, 1'b1);
        cyc("bne_fetch", e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("bne_dec",   e_decode(0),     1'b1, 1'b1, 6'b000101, 1'b0);
        cyc("bne_br",    e_branch(0),     1'b1, 1'b1, 6'b000100, 1'b1);
        cyc("bne_fetch2",e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("bne_dec2",  e_decode(0),     1'b1, 1'b1, 6'b000101, 1'b0);
        cyc("bne_br_nz", e_branch(1),     1'b1, 1'b1, 6'b000000, 1'b0);

        // ori, andi, addi.
        cyc("ori_fetch", e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("ori_dec",   e_decode(0),     1'b1, 1'b1, 6'b001101, 1'b0);
        cyc("ori_exec",  e_exec_i(3'b111),1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("ori_wb",    e_alu_wb(0),     1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("andi_fetch",e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("andi_dec",  e_decode(0),     1'b1, 1'b1, 6'b001100, 1'b0);
        cyc("andi_exec", e_exec_i(3'b101),1'b1, 1'b1, 6'b001101, 1'b0);
        cyc("andi_wb",   e_alu_wb(0),     1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("addi_fetch",e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("addi_dec",  e_decode(0),     1'b1, 1'b1, 6'b001000, 1'b0);
        cyc("addi_exec", e_exec_i(3'b100),1'b1, 1'b1, 6'b001100, 1'b0);
        cyc("addi_wb",   e_alu_wb(0),     1'b1, 1'b1, 6'b000000, 1'b0);

        // sw with mem_ready stuck low: 15 quiet wait cycles, then bus_error and abort.
        cyc("sw_fetch",  e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("sw_dec",    e_decode(0),     1'b1, 1'b1, 6'b101011, 1'b0);
        cyc("sw_addr",   e_memaddr(),     1'b1, 1'b1, 6'b100011, 1'b0);
        for (int i = 0; i < 15; i++)
            cyc("sw_wait", e_memwr(0, 0), 1'b1, 1'b0, 6'b000000, 1'b0);
        cyc("sw_tmo",    e_memwr(0, 1),   1'b1, 1'b0, 6'b000000, 1'b0);

        // Now back in FETCH: timeout there retries FETCH.
        for (int i = 0; i < 15; i++)
            cyc("f_wait",  e_fetch(0, 0), 1'b1, 1'b0, 6'b000000, 1'b0);
        cyc("f_tmo",     e_fetch(0, 1),   1'b1, 1'b0, 6'b000000, 1'b0);
        cyc("f_retry",   e_fetch(0, 0),   1'b1, 1'b0, 6'b000000, 1'b0);
        cyc("f_ok",      e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);

        // Illegal opcode in DECODE.
        cyc("ill_dec",   e_decode(1),     1'b1, 1'b1, 6'b111111, 1'b0);
        cyc("ill_fetch", e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);

        // Jump.
        cyc("j_dec",     e_decode(0),     1'b1, 1'b1, 6'b000010, 1'b0);
        cyc("j_jump",    e_jump(),        1'b1, 1'b1, 6'b000000, 1'b0);

        // Reset asserted mid MEM_READ: outputs drop the same cycle, restart from IDLE.
        cyc("rm_fetch",  e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);
        cyc("rm_dec",    e_decode(0),     1'b1, 1'b1, 6'b100011, 1'b0);
        cyc("rm_addr",   e_memaddr(),     1'b1, 1'b1, 6'b100011, 1'b0);
        cyc("rm_wait",   e_memrd(),       1'b1, 1'b0, 6'b100011, 1'b0);
        cyc("rm_reset",  e_zero(),        1'b0, 1'b1, 6'b100011, 1'b0);
        cyc("rm_hold",   e_zero(),        1'b0, 1'b1, 6'b100011, 1'b0);
        cyc("rm_idle",   e_zero(),        1'b1, 1'b1, 6'b100011, 1'b0);
        cyc("rm_fetch2", e_fetch(1, 0),   1'b1, 1'b1, 6'b000000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
